// File: rtl/gtp_rx_deframer.sv
// GTP receive deframer: lane-aligns the 16-bit 8b/10b-decoded stream, acquires
// link sync on K28.5 idles, and extracts SOF/EOF-delimited frames into a
// valid/sof/last word stream. Aborted frames are pulsed and counted.
module gtp_rx_deframer #(
  parameter int unsigned SYNC_CNT = 16,
  parameter int unsigned ERR_MAX  = 4,
  parameter int unsigned MAX_LEN  = 1024
) (
  input  logic        rx_clk,
  input  logic        rxresetdone,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rxcharisk,
  output logic        link_up,
  output logic        comma_swap,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_last,
  output logic        frame_err,
  output logic [15:0] frame_err_cnt
);

  localparam int unsigned CNT_W = $clog2(SYNC_CNT + 1);
  localparam int unsigned ERR_W = $clog2(ERR_MAX + 1);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  typedef enum logic [2:0] {W_IDLE, W_SOF, W_EOF, W_DATA, W_BAD} wcls_t;
  typedef enum logic [1:0] {S_LOS, S_CHECK, S_SYNC} sync_t;
  typedef enum logic {F_IDLE, F_DATA} frm_t;

  logic [15:0]      prev_q, a_word_q;
  logic [1:0]       prev_k_q, a_k_q;
  wcls_t            wcls;
  logic             comma0, comma1;

  sync_t            sst_q, sst_d;
  logic             swap_q, swap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       blank_q, blank_d;
  logic             link_up_q;

  frm_t             fst_q, fst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             hold_sof_q, hold_sof_d;
  logic [15:0]      m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_sof_q, m_sof_d;
  logic             m_last_q, m_last_d;
  logic             ferr_q, ferr_d;
  logic [15:0]      ferr_cnt_q;

  assign comma0 = rxcharisk[0] && (rx_data[7:0]  == K28_5);
  assign comma1 = rxcharisk[1] && (rx_data[15:8] == K28_5);

  // Lane alignment: with swap set, byte1 of the previous word pairs with byte0 of the current one
  always_ff @(posedge rx_clk or negedge rxresetdone) begin
    if (!rxresetdone) begin
      prev_q   <= '0;
      prev_k_q <= '0;
      a_word_q <= '0;
      a_k_q    <= '0;
    end else begin
      prev_q   <= rx_data;
      prev_k_q <= rxcharisk;
      if (swap_q) begin
        a_word_q <= {rx_data[7:0], prev_q[15:8]};
        a_k_q    <= {rxcharisk[0], prev_k_q[1]};
      end else begin
        a_word_q <= prev_q;
        a_k_q    <= prev_k_q;
      end
    end
  end

  // Classify the aligned word
  always_comb begin
    wcls = W_BAD;
    if (a_k_q == 2'b00) begin
      wcls = W_DATA;
    end else if (a_k_q == 2'b01) begin
      case (a_word_q[7:0])
        K28_5:   wcls = W_IDLE;
        K27_7:   wcls = W_SOF;
        K29_7:   wcls = W_EOF;
        default: wcls = W_BAD;
      endcase
    end
  end

  // Link sync next-state: comma hunt, idle qualification, error-based drop
  always_comb begin
    sst_d   = sst_q;
    swap_d  = swap_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    blank_d = blank_q;
    case (sst_q)
      S_LOS: begin
        if (comma0 || comma1) begin
          swap_d  = !comma0;
          sst_d   = S_CHECK;
          cnt_d   = '0;
          blank_d = 2'd2;
        end
      end
      S_CHECK: begin
        // The align pipeline still holds words paired under the old swap setting
        if (blank_q != 2'd0) begin
          blank_d = blank_q - 2'd1;
        end else if (wcls == W_IDLE) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SYNC_CNT - 1)) begin
            sst_d = S_SYNC;
            err_d = '0;
          end
        end else if (wcls == W_BAD) begin
          sst_d = S_LOS;
        end
      end
      S_SYNC: begin
        if (wcls == W_BAD) begin
          err_d = err_q + 1'b1;
          if (err_q == ERR_W'(ERR_MAX - 1)) begin
            sst_d = S_LOS;
          end
        end else if (wcls == W_IDLE) begin
          err_d = '0;
        end
      end
      default: sst_d = S_LOS;
    endcase
  end

  // Link sync state register
  always_ff @(posedge rx_clk or negedge rxresetdone) begin
    if (!rxresetdone) begin
      sst_q     <= S_LOS;
      swap_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= '0;
      blank_q   <= '0;
      link_up_q <= 1'b0;
    end else begin
      sst_q     <= sst_d;
      swap_q    <= swap_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      blank_q   <= blank_d;
      link_up_q <= (sst_q == S_SYNC);
    end
  end

  // Frame extraction next-state: one-word hold so the final word can carry m_last
  always_comb begin
    fst_d      = fst_q;
    len_d      = len_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    hold_sof_d = hold_sof_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    m_sof_d    = 1'b0;
    m_last_d   = 1'b0;
    ferr_d     = 1'b0;
    if (sst_q != S_SYNC) begin
      if (fst_q == F_DATA) begin
        ferr_d   = 1'b1;
        hold_v_d = 1'b0;
        fst_d    = F_IDLE;
      end
    end else begin
      case (fst_q)
        F_IDLE: begin
          if (wcls == W_SOF) begin
            fst_d    = F_DATA;
            len_d    = '0;
            hold_v_d = 1'b0;
          end
        end
        F_DATA: begin
          case (wcls)
            W_DATA: begin
              if (len_q == LEN_W'(MAX_LEN)) begin
                ferr_d   = 1'b1;
                hold_v_d = 1'b0;
                fst_d    = F_IDLE;
              end else begin
                if (hold_v_q) begin
                  m_valid_d = 1'b1;
                  m_data_d  = hold_q;
                  m_sof_d   = hold_sof_q;
                end
                hold_d     = a_word_q;
                hold_sof_d = !hold_v_q;
                hold_v_d   = 1'b1;
                len_d      = len_q + 1'b1;
              end
            end
            W_EOF: begin
              if (hold_v_q) begin
                m_valid_d = 1'b1;
                m_data_d  = hold_q;
                m_sof_d   = hold_sof_q;
                m_last_d  = 1'b1;
              end
              hold_v_d = 1'b0;
              fst_d    = F_IDLE;
            end
            W_SOF: begin
              ferr_d   = 1'b1;
              hold_v_d = 1'b0;
              len_d    = '0;
            end
            default: begin
              ferr_d   = 1'b1;
              hold_v_d = 1'b0;
              fst_d    = F_IDLE;
            end
          endcase
        end
        default: fst_d = F_IDLE;
      endcase
    end
  end

  // Frame state, hold register, output stream and saturating error counter
  always_ff @(posedge rx_clk or negedge rxresetdone) begin
    if (!rxresetdone) begin
      fst_q      <= F_IDLE;
      len_q      <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      hold_sof_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_last_q   <= 1'b0;
      ferr_q     <= 1'b0;
      ferr_cnt_q <= '0;
    end else begin
      fst_q      <= fst_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      hold_sof_q <= hold_sof_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_last_q   <= m_last_d;
      ferr_q     <= ferr_d;
      if (ferr_d && (ferr_cnt_q != '1)) begin
        ferr_cnt_q <= ferr_cnt_q + 16'd1;
      end
    end
  end

  assign link_up       = link_up_q;
  assign comma_swap    = swap_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_sof         = m_sof_q;
  assign m_last        = m_last_q;
  assign frame_err     = ferr_q;
  assign frame_err_cnt = ferr_cnt_q;

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Bench for gtp_rx_deframer: random frames in both lane pairings, sync
// acquisition/loss and reset, checked through an expected-output queue.
module tb_gtp_rx_deframer;

  localparam int unsigned SYNC_CNT = 16;
  localparam int unsigned ERR_MAX  = 4;
  localparam int unsigned MAX_LEN  = 4;

  localparam logic [15:0] IDLE_W = 16'h00BC;
  localparam logic [15:0] SOF_W  = 16'h00FB;
  localparam logic [15:0] EOF_W  = 16'h00FD;
  localparam logic [15:0] BAD_W  = 16'hFFFF;

  logic        rx_clk = 1'b0;
  logic        rxresetdone = 1'b0;
  logic [15:0] rx_data = '0;
  logic [1:0]  rxcharisk = '0;
  logic        link_up, comma_swap, m_valid, m_sof, m_last, frame_err;
  logic [15:0] m_data, frame_err_cnt;

  gtp_rx_deframer #(
    .SYNC_CNT(SYNC_CNT),
    .ERR_MAX (ERR_MAX),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .rx_clk       (rx_clk),
    .rxresetdone  (rxresetdone),
    .rx_data      (rx_data),
    .rxcharisk    (rxcharisk),
    .link_up      (link_up),
    .comma_swap   (comma_swap),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_sof        (m_sof),
    .m_last       (m_last),
    .frame_err    (frame_err),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
    logic        sof;
    logic        last;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_errs = 0;
  bit          mon_en = 1'b0;
  bit          lane_swap = 1'b0;
  logic [15:0] pw = IDLE_W;
  logic [1:0]  pk = 2'b01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one logical word; in swapped mode its bytes straddle two rx words
  task automatic send(input logic [15:0] w, input logic [1:0] k);
    @(negedge rx_clk);
    if (lane_swap) begin
      rx_data   = {w[7:0], pw[15:8]};
      rxcharisk = {k[0], pk[1]};
    end else begin
      rx_data   = w;
      rxcharisk = k;
    end
    pw = w;
    pk = k;
  endtask

  task automatic push_word(input logic [15:0] d, input logic sof, input logic last);
    expq.push_back('{err: 1'b0, data: d, sof: sof, last: last});
  endtask

  task automatic push_err();
    expq.push_back('{err: 1'b1, data: 16'h0, sof: 1'b0, last: 1'b0});
    exp_errs++;
  endtask

  // term: 0 = EOF, 1 = IDLE (abort), 2 = SOF (abort, opens the next frame)
  task automatic send_frame(input int len, input int term, input bit with_sof);
    logic [15:0] words[$];
    for (int i = 0; i < len; i++) words.push_back(16'($urandom()));
    if (len > int'(MAX_LEN)) begin
      for (int i = 0; i < int'(MAX_LEN) - 1; i++) push_word(words[i], i == 0, 1'b0);
      push_err();
    end else if (term == 0) begin
      for (int i = 0; i < len; i++) push_word(words[i], i == 0, i == len - 1);
    end else begin
      for (int i = 0; i < len - 1; i++) push_word(words[i], i == 0, 1'b0);
      push_err();
    end
    if (with_sof) send(SOF_W, 2'b01);
    for (int i = 0; i < len; i++) send(words[i], 2'b00);
    case (term)
      0:       send(EOF_W, 2'b01);
      1:       send(IDLE_W, 2'b01);
      default: send(SOF_W, 2'b01);
    endcase
  endtask

  task automatic run_frames(input int count);
    bit with_sof = 1'b1;
    int term;
    for (int f = 0; f < count; f++) begin
      term = (f == count - 1) ? 0 : int'($urandom_range(0, 2));
      send_frame(int'($urandom_range(0, 6)), term, with_sof);
      with_sof = (term != 2);
      if (term != 2) repeat ($urandom_range(0, 2)) send(IDLE_W, 2'b01);
    end
  endtask

  task automatic idle_until_up(input int max, output int n);
    n = 0;
    do begin
      send(IDLE_W, 2'b01);
      @(posedge rx_clk);
      #1;
      n++;
    end while (!link_up && n < max);
  endtask

  task automatic drain(input string name);
    int t = 0;
    repeat (8) send(IDLE_W, 2'b01);
    while (expq.size() > 0 && t < 40) begin
      send(IDLE_W, 2'b01);
      t++;
    end
    @(posedge rx_clk);
    #2;
    chk(name, expq.size(), 0);
  endtask

  // Monitor: every output event must match the next expected entry
  always @(posedge rx_clk) begin
    #1;
    if (mon_en && rxresetdone && (m_valid || frame_err)) begin
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got valid=%0b err=%0b data=%0h, expected nothing",
                 m_valid, frame_err, m_data);
      end else begin
        mon_e = expq.pop_front();
        chk("out_event", {13'h0, frame_err, (m_valid ? m_data : 16'h0), m_sof, m_last},
            {13'h0, mon_e.err, mon_e.data, mon_e.sof, mon_e.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  stay;
    int  bads;

    #12;
    chk("reset_outputs", {link_up, comma_swap, m_valid, m_sof, m_last, frame_err, m_data, frame_err_cnt}, 0);
    @(negedge rx_clk);
    rxresetdone = 1'b1;

    // Acquire sync with commas in byte0
    idle_until_up(60, n);
    chk("sync_latency_lane0", n, SYNC_CNT + 4);
    chk("comma_swap_lane0", comma_swap, 0);
    mon_en = 1'b1;

    run_frames(40);
    drain("drain_lane0");
    chk("err_cnt_lane0", frame_err_cnt, exp_errs);

    // Three BAD words followed by an IDLE never reach the drop threshold
    stay = 1'b1;
    repeat (2) begin
      repeat (3) begin
        send(BAD_W, 2'b11);
        @(posedge rx_clk); #1;
        if (!link_up) stay = 1'b0;
      end
      send(IDLE_W, 2'b01);
      @(posedge rx_clk); #1;
      if (!link_up) stay = 1'b0;
    end
    repeat (6) begin
      send(IDLE_W, 2'b01);
      @(posedge rx_clk); #1;
      if (!link_up) stay = 1'b0;
    end
    chk("link_hold_3bad", stay, 1);

    // Partial frame cut by BAD words, which then drop the link
    begin
      logic [15:0] d0, d1;
      d0 = 16'($urandom());
      d1 = 16'($urandom());
      push_word(d0, 1'b1, 1'b0);
      push_err();
      send(SOF_W, 2'b01);
      send(d0, 2'b00);
      send(d1, 2'b00);
    end
    bads = 0;
    do begin
      send(BAD_W, 2'b11);
      @(posedge rx_clk); #1;
      bads++;
    end while (link_up && bads < 12);
    chk("link_drop_4bad", link_up, 0);
    chk("bad_words_to_drop", bads, ERR_MAX + 3);
    repeat (3) send(BAD_W, 2'b11);
    chk("queue_after_drop", expq.size(), 0);
    chk("err_cnt_after_drop", frame_err_cnt, exp_errs);

    // Reacquire with commas in byte1
    lane_swap = 1'b1;
    pw = IDLE_W;
    pk = 2'b01;
    idle_until_up(80, n);
    chk("link_up_lane1", link_up, 1);
    chk("comma_swap_lane1", comma_swap, 1);

    push_word(16'h1111, 1'b1, 1'b0);
    push_word(16'h2222, 1'b0, 1'b1);
    send(SOF_W, 2'b01);
    send(16'h1111, 2'b00);
    send(16'h2222, 2'b00);
    send(EOF_W, 2'b01);
    send(IDLE_W, 2'b01);
    // Empty frame: no output and no error
    send(SOF_W, 2'b01);
    send(EOF_W, 2'b01);
    run_frames(40);
    drain("drain_lane1");
    chk("err_cnt_lane1", frame_err_cnt, exp_errs);

    // Reset in the middle of a frame clears everything at once
    mon_en = 1'b0;
    send(SOF_W, 2'b01);
    repeat (4) send(16'($urandom()), 2'b00);
    send(16'($urandom()), 2'b00);
    @(posedge rx_clk); #1;
    chk("link_up_before_reset", link_up, 1);
    @(negedge rx_clk);
    #2;
    rxresetdone = 1'b0;
    #1;
    chk("reset_mid_frame", {link_up, comma_swap, m_valid, m_sof, m_last, frame_err, m_data, frame_err_cnt}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
